// File: rtl/regfile_read_arbiter_if.sv
// Register-file read arbiter bus: requester handshake plus the shared read-mux hookup.
// Latency: none (wires only).
// Backpressure: requesters hold req/addr until their ack bit pulses.
//
// Signals (named from the arbiter's point of view):
//   req_i      N_REQ        per-requester read request, held until ack
//   addr_i     N_REQ*SIZE   requester k address at [k*SIZE +: SIZE]
//   mux_sel_o  SIZE         registered select to the register-file read mux
//   mux_data_i WIDTH        read-mux output, combinational from mux_sel_o
//   gnt_o      N_REQ        one-hot requester whose address is on mux_sel_o
//   ack_o      N_REQ        one-hot, single-cycle pulse: rdata_o valid for it
//   rdata_o    WIDTH        registered read data
interface regfile_read_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 5,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]      req_i;
  logic [N_REQ*SIZE-1:0] addr_i;
  logic [SIZE-1:0]       mux_sel_o;
  logic [WIDTH-1:0]      mux_data_i;
  logic [N_REQ-1:0]      gnt_o;
  logic [N_REQ-1:0]      ack_o;
  logic [WIDTH-1:0]      rdata_o;

  // Arbiter side.
  modport slave (
    input  req_i,
    input  addr_i,
    input  mux_data_i,
    output mux_sel_o,
    output gnt_o,
    output ack_o,
    output rdata_o
  );

  // Requester / register-file side.
  modport master (
    output req_i,
    output addr_i,
    output mux_data_i,
    input  mux_sel_o,
    input  gnt_o,
    input  ack_o,
    input  rdata_o
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 32:1 register-file read mux among N_REQ requesters.
// Latency: 2 edges from sampled request to ack_o/rdata_o (grant edge, capture edge).
// Backpressure: requesters hold req/addr until ack; at most one grant per cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; drops any read in flight (no ack issued)
//   bus    regfile_read_arbiter_if.slave (request/grant/ack handshake + mux hookup)
module regfile_read_arbiter #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 5,
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_read_arbiter_if.slave  bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One extra bit so ptr + offset never overflows before the wrap correction.
  localparam int IW = PW + 1;

  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] gnt_d;
  logic [N_REQ-1:0] ack_q;
  logic [SIZE-1:0]  mux_sel_q;
  logic [SIZE-1:0]  mux_sel_d;
  logic [WIDTH-1:0] rdata_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;

  logic [N_REQ-1:0] eligible;
  logic [PW-1:0]    win;
  logic             found;
  logic [IW-1:0]    idx;

  // The requester already holding the mux is masked so a single held request
  // is not granted a second time while its data is still being captured.
  always_comb begin
    eligible = bus.req_i & ~gnt_q;
  end

  // Round-robin search: first eligible bit at ptr, ptr+1, ... wrapping at N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_q} + IW'(i);
      if (idx >= IW'(N_REQ)) begin
        idx = idx - IW'(N_REQ);
      end
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  // Next-state for the grant stage. Only meaningful when found is set.
  always_comb begin
    gnt_d      = '0;
    gnt_d[win] = found;
    mux_sel_d  = bus.addr_i[win*SIZE +: SIZE];
    ptr_d      = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q     <= '0;
      ack_q     <= '0;
      mux_sel_q <= '0;
      rdata_q   <= '0;
      ptr_q     <= '0;
    end else begin
      // Stage 1: grant and drive the mux select. Select and pointer hold when idle.
      if (found) begin
        gnt_q     <= gnt_d;
        mux_sel_q <= mux_sel_d;
        ptr_q     <= ptr_d;
      end else begin
        gnt_q     <= '0;
      end

      // Stage 2: capture the mux output for last cycle's grant and ack it.
      ack_q <= gnt_q;
      if (|gnt_q) begin
        rdata_q <= bus.mux_data_i;
      end
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.ack_o     = ack_q;
  assign bus.mux_sel_o = mux_sel_q;
  assign bus.rdata_o   = rdata_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
module tb_regfile_read_arbiter;

  localparam int WIDTH = 32;
  localparam int SIZE  = 5;
  localparam int N_REQ = 4;

  typedef struct packed {
    logic [N_REQ-1:0] ack;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  int gseq2[6] = '{0, 1, 2, 3, 0, 1};
  int gseq3[4] = '{0, 2, 0, 2};

  regfile_read_arbiter_if #(.WIDTH(WIDTH), .SIZE(SIZE), .N_REQ(N_REQ)) bus ();

  regfile_read_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE), .N_REQ(N_REQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register-file model: register r reads as 32'hDEAD0000 + r.
  assign bus.mux_data_i = 32'hDEAD0000 | {27'b0, bus.mux_sel_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N_REQ-1:0] a, input logic [WIDTH-1:0] d);
    exp_t e;
    e.ack  = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_addr(input int k, input logic [SIZE-1:0] v);
    bus.addr_i[k*SIZE +: SIZE] = v;
  endtask

  // Scoreboard monitor: every ack pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (bus.ack_o !== '0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", 32'(bus.ack_o), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_ack", 32'(bus.ack_o), 32'(mon_e.ack));
        chk("sb_rdata", bus.rdata_o, mon_e.data);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    bus.req_i  = '0;
    bus.addr_i = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
    chk("rst_ack", 32'(bus.ack_o), 32'h0);
    chk("rst_sel", 32'(bus.mux_sel_o), 32'h0);
    chk("rst_rdata", bus.rdata_o, 32'h0);
    reset = 1'b0;

    // 1. Single read from requester 0, address 7.
    set_addr(0, 5'd7);
    bus.req_i = 4'b0001;
    push(4'b0001, 32'hDEAD0007);
    tick();
    chk("t1_sel", 32'(bus.mux_sel_o), 32'd7);
    chk("t1_gnt", 32'(bus.gnt_o), 32'h1);
    chk("t1_ack_early", 32'(bus.ack_o), 32'h0);
    tick();
    chk("t1_ack", 32'(bus.ack_o), 32'h1);
    chk("t1_rdata", bus.rdata_o, 32'hDEAD0007);
    chk("t1_no_regrant", 32'(bus.gnt_o), 32'h0);
    bus.req_i = 4'b0000;
    tick();
    chk("t1_ack_clear", 32'(bus.ack_o), 32'h0);

    // 2. All four requesters held: grants 0,1,2,3,0,1 with acks one cycle later.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < N_REQ; k++) set_addr(k, SIZE'(10 + k));
    bus.req_i = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      push(4'(1 << gseq2[i]), 32'hDEAD000A + 32'(gseq2[i]));
      tick();
      chk("t2_gnt", 32'(bus.gnt_o), 32'(1 << gseq2[i]));
      chk("t2_ack", 32'(bus.ack_o), (i == 0) ? 32'h0 : 32'(1 << gseq2[i-1]));
    end
    bus.req_i = 4'b0000;
    tick();
    chk("t2_gnt_idle", 32'(bus.gnt_o), 32'h0);
    chk("t2_ack_last", 32'(bus.ack_o), 32'h2);

    // 3. Requesters 0 and 2 held: grants alternate 0,2,0,2.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_i = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      push(4'(1 << gseq3[i]), 32'hDEAD000A + 32'(gseq3[i]));
      tick();
      chk("t3_gnt", 32'(bus.gnt_o), 32'(1 << gseq3[i]));
    end
    bus.req_i = 4'b0000;
    tick();
    chk("t3_ack_last", 32'(bus.ack_o), 32'h4);

    // 4. Address 31 from requester 3, then pointer wraps to 0 and address 0 passes.
    set_addr(3, 5'd31);
    bus.req_i = 4'b1000;
    push(4'b1000, 32'hDEAD001F);
    tick();
    chk("t4_sel31", 32'(bus.mux_sel_o), 32'd31);
    chk("t4_gnt3", 32'(bus.gnt_o), 32'h8);
    tick();
    chk("t4_rdata31", bus.rdata_o, 32'hDEAD001F);
    bus.req_i = 4'b0000;
    set_addr(0, 5'd0);
    set_addr(3, 5'd5);
    bus.req_i = 4'b1001;
    push(4'b0001, 32'hDEAD0000);
    push(4'b1000, 32'hDEAD0005);
    tick();
    chk("t4_wrap_gnt0", 32'(bus.gnt_o), 32'h1);
    chk("t4_sel0", 32'(bus.mux_sel_o), 32'd0);
    tick();
    chk("t4_gnt3b", 32'(bus.gnt_o), 32'h8);
    chk("t4_rdata0", bus.rdata_o, 32'hDEAD0000);
    bus.req_i = 4'b1000;
    tick();
    chk("t4_masked", 32'(bus.gnt_o), 32'h0);
    bus.req_i = 4'b0000;

    // 6. Idle after acks: select and data hold.
    tick();
    tick();
    chk("t6_gnt", 32'(bus.gnt_o), 32'h0);
    chk("t6_ack", 32'(bus.ack_o), 32'h0);
    chk("t6_sel_hold", 32'(bus.mux_sel_o), 32'd5);
    chk("t6_rdata_hold", bus.rdata_o, 32'hDEAD0005);

    // 5. Reset the cycle after a grant: no ack, outputs cleared, pointer back to 0.
    set_addr(1, 5'd9);
    bus.req_i = 4'b0010;
    tick();
    chk("t5_gnt1", 32'(bus.gnt_o), 32'h2);
    reset = 1'b1;
    tick();
    chk("t5_rst_gnt", 32'(bus.gnt_o), 32'h0);
    chk("t5_rst_ack", 32'(bus.ack_o), 32'h0);
    chk("t5_rst_sel", 32'(bus.mux_sel_o), 32'h0);
    chk("t5_rst_rdata", bus.rdata_o, 32'h0);
    reset = 1'b0;
    set_addr(0, 5'd3);
    set_addr(2, 5'd20);
    bus.req_i = 4'b0101;
    push(4'b0001, 32'hDEAD0003);
    push(4'b0100, 32'hDEAD0014);
    tick();
    chk("t5_ptr0_gnt", 32'(bus.gnt_o), 32'h1);
    chk("t5_sel3", 32'(bus.mux_sel_o), 32'd3);
    tick();
    chk("t5_gnt2", 32'(bus.gnt_o), 32'h4);
    chk("t5_sel20", 32'(bus.mux_sel_o), 32'd20);
    bus.req_i = 4'b0100;
    tick();
    chk("t5_rdata20", bus.rdata_o, 32'hDEAD0014);
    bus.req_i = 4'b0000;
    tick();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
